// File: rtl/alu_slice_seq.sv
// Multi-cycle 181-style ALU: walks WIDTH/SLICE slices LSB-first, one per clock, carry held in a flop.
// Latency NSL cycles from accept to the done pulse; start is ignored while busy, with no other backpressure.
module alu_slice_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin_re,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             cout_re,
  output logic             zero,
  output logic             ovf
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_s;
  logic               r_m;
  logic               r_carry;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_y;
  logic               r_cout_re;
  logic               r_zero;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [SLICE-1:0]   w_sa;
  logic [SLICE-1:0]   w_sb;
  logic [SLICE-1:0]   w_p;
  logic [SLICE-1:0]   w_q;
  logic [SLICE-1:0]   w_lres;
  logic [SLICE:0]     w_sum;
  logic [SLICE-1:0]   w_res;
  logic               w_cout;
  logic               w_cmsb;
  logic [WIDTH-1:0]   w_y_nxt;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == LAST) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_sa = r_a[r_cnt*SLICE +: SLICE];
  assign w_sb = r_b[r_cnt*SLICE +: SLICE];

  always_comb begin
    w_lres = '0;
    case (r_s)
      4'h0: w_lres = ~w_sa;
      4'h1: w_lres = ~(w_sa | w_sb);
      4'h2: w_lres = ~w_sa & w_sb;
      4'h3: w_lres = '0;
      4'h4: w_lres = ~(w_sa & w_sb);
      4'h5: w_lres = ~w_sb;
      4'h6: w_lres = w_sa ^ w_sb;
      4'h7: w_lres = w_sa & ~w_sb;
      4'h8: w_lres = ~w_sa | w_sb;
      4'h9: w_lres = ~(w_sa ^ w_sb);
      4'ha: w_lres = w_sb;
      4'hb: w_lres = w_sa & w_sb;
      4'hc: w_lres = '1;
      4'hd: w_lres = w_sa | ~w_sb;
      4'he: w_lres = w_sa | w_sb;
      default: w_lres = w_sa;
    endcase
  end

  // Arithmetic codes are all P + Q + carry; only the P/Q operand pair differs.
  always_comb begin
    w_p = '0;
    w_q = '0;
    case (r_s)
      4'h0: begin w_p = w_sa;          w_q = '0;            end
      4'h1: begin w_p = w_sa | w_sb;   w_q = '0;            end
      4'h2: begin w_p = w_sa | ~w_sb;  w_q = '0;            end
      4'h3: begin w_p = '0;            w_q = '1;            end
      4'h4: begin w_p = w_sa;          w_q = w_sa & ~w_sb;  end
      4'h5: begin w_p = w_sa | w_sb;   w_q = w_sa & ~w_sb;  end
      4'h6: begin w_p = w_sa;          w_q = ~w_sb;         end
      4'h7: begin w_p = w_sa & ~w_sb;  w_q = '1;            end
      4'h8: begin w_p = w_sa;          w_q = w_sa & w_sb;   end
      4'h9: begin w_p = w_sa;          w_q = w_sb;          end
      4'ha: begin w_p = w_sa | ~w_sb;  w_q = w_sa & w_sb;   end
      4'hb: begin w_p = w_sa & w_sb;   w_q = '1;            end
      4'hc: begin w_p = w_sa;          w_q = w_sa;          end
      4'hd: begin w_p = w_sa | w_sb;   w_q = w_sa;          end
      4'he: begin w_p = w_sa | ~w_sb;  w_q = w_sa;          end
      default: begin w_p = w_sa;       w_q = '1;            end
    endcase
  end

  assign w_sum  = {1'b0, w_p} + {1'b0, w_q} + (SLICE+1)'(r_carry);
  assign w_res  = r_m ? w_lres : w_sum[SLICE-1:0];
  assign w_cout = r_m ? 1'b0 : w_sum[SLICE];
  // Carry into the slice MSB recovered from the MSB sum bit; only meaningful on the top slice.
  assign w_cmsb = w_p[SLICE-1] ^ w_q[SLICE-1] ^ w_sum[SLICE-1];

  always_comb begin
    w_y_nxt = r_y;
    w_y_nxt[r_cnt*SLICE +: SLICE] = w_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_s       <= '0;
      r_m       <= 1'b0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_y       <= '0;
      r_cout_re <= 1'b1;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_s     <= s;
        r_m     <= m;
        r_carry <= ~cin_re;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (r_state == ST_RUN) begin
        r_y     <= w_y_nxt;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_cnt     <= '0;
          r_busy    <= 1'b0;
          r_done    <= 1'b1;
          r_cout_re <= r_m ? 1'b1 : ~w_cout;
          r_zero    <= (w_y_nxt == '0);
          r_ovf     <= r_m ? 1'b0 : (w_cmsb ^ w_cout);
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign y       = r_y;
  assign cout_re = r_cout_re;
  assign zero    = r_zero;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_alu_slice_seq.sv
// Bench for alu_slice_seq: expected results queued at issue, popped and compared on done.
module tb_alu_slice_seq;
  localparam int W   = 16;
  localparam int SL  = 4;
  localparam int NSL = W / SL;

  logic         clk = 1'b0;
  logic         rst, start, m, cin_re;
  logic [W-1:0] a, b;
  logic [3:0]   s;
  logic         busy, done, cout_re, zero, ovf;
  logic [W-1:0] y;

  typedef struct packed {
    logic [W-1:0] y;
    logic         cout_re;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_slice_seq #(.WIDTH(W), .SLICE(SL)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s), .m(m),
    .cin_re(cin_re), .busy(busy), .done(done), .y(y), .cout_re(cout_re),
    .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<500000", $time);
    $fatal(1);
  end

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [3:0] ms, input logic mm, input logic mcr);
    logic [W-1:0] p, q, r;
    logic [W:0]   u, sg;
    logic         cin;
    exp_t         e;
    cin = ~mcr;
    p = '0; q = '0; r = '0; u = '0; sg = '0;
    if (mm) begin
      case (ms)
        4'h0: r = ~ma;          4'h1: r = ~(ma | mb);
        4'h2: r = ~ma & mb;     4'h3: r = '0;
        4'h4: r = ~(ma & mb);   4'h5: r = ~mb;
        4'h6: r = ma ^ mb;      4'h7: r = ma & ~mb;
        4'h8: r = ~ma | mb;     4'h9: r = ~(ma ^ mb);
        4'ha: r = mb;           4'hb: r = ma & mb;
        4'hc: r = '1;           4'hd: r = ma | ~mb;
        4'he: r = ma | mb;      default: r = ma;
      endcase
      e.y = r; e.cout_re = 1'b1; e.ovf = 1'b0;
    end else begin
      case (ms)
        4'h0: begin p = ma;        q = '0;        end
        4'h1: begin p = ma | mb;   q = '0;        end
        4'h2: begin p = ma | ~mb;  q = '0;        end
        4'h3: begin p = '0;        q = '1;        end
        4'h4: begin p = ma;        q = ma & ~mb;  end
        4'h5: begin p = ma | mb;   q = ma & ~mb;  end
        4'h6: begin p = ma;        q = ~mb;       end
        4'h7: begin p = ma & ~mb;  q = '1;        end
        4'h8: begin p = ma;        q = ma & mb;   end
        4'h9: begin p = ma;        q = mb;        end
        4'ha: begin p = ma | ~mb;  q = ma & mb;   end
        4'hb: begin p = ma & mb;   q = '1;        end
        4'hc: begin p = ma;        q = ma;        end
        4'hd: begin p = ma | mb;   q = ma;        end
        4'he: begin p = ma | ~mb;  q = ma;        end
        default: begin p = ma;     q = '1;        end
      endcase
      u  = {1'b0, p} + {1'b0, q} + {{W{1'b0}}, cin};
      sg = {p[W-1], p} + {q[W-1], q} + {{W{1'b0}}, cin};
      e.y = u[W-1:0]; e.cout_re = ~u[W]; e.ovf = sg[W] ^ sg[W-1];
    end
    e.zero = (e.y == '0);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] is_,
                       input logic im, input logic icr, input exp_t e);
    a = ia; b = ib; s = is_; m = im; cin_re = icr; start = 1'b1;
    sb.push_back(e);
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output bit got);
    lat = 0; got = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (done) begin lat = i; got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin_re = 1'b1;
    cyc(); cyc();
    checks++;
    if ({busy, done, y, cout_re, zero, ovf} !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b y=%h cout_re=%b zero=%b ovf=%b required 0 0 0000 1 0 0",
               busy, done, y, cout_re, zero, ovf);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    exp_t e;
    issue(16'h1234, 16'h0FFF, 4'h9, 1'b0, 1'b1, exp_t'({16'h2233, 1'b1, 1'b0, 1'b0}));
    for (int i = 0; i < NSL; i++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++;
        $display("FAIL basic_busy cycle %0d got busy=%b done=%b required 1 0", i, busy, done);
      end
      cyc();
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++;
      $display("FAIL basic_done_edge got busy=%b done=%b required 0 1", busy, done);
    end
    e = sb.pop_front();
    checks++;
    if ({y, cout_re, zero, ovf} !== e) begin
      errors++;
      $display("FAIL basic_result got %h required %h", {y, cout_re, zero, ovf}, e);
    end
    cyc();
    checks++;
    if (done !== 1'b0 || y !== 16'h2233) begin
      errors++;
      $display("FAIL basic_pulse_hold got done=%b y=%h required 0 2233", done, y);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[8] = '{16'h0005, 16'h8000, 16'h0000, 16'h0000, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h1234};
    logic [W-1:0] vb[8] = '{16'h0007, 16'h0001, 16'h0000, 16'h0000, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0FFF};
    logic [3:0]   vs[8] = '{4'h6, 4'h6, 4'hf, 4'hf, 4'h6, 4'h3, 4'hc, 4'h9};
    logic         vm[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         vc[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_t         ve[8] = '{exp_t'({16'hFFFE, 3'b100}), exp_t'({16'h7FFF, 3'b001}),
                            exp_t'({16'hFFFF, 3'b100}), exp_t'({16'h0000, 3'b010}),
                            exp_t'({16'h0FF0, 3'b100}), exp_t'({16'h0000, 3'b110}),
                            exp_t'({16'hFFFF, 3'b100}), exp_t'({16'h2233, 3'b100})};
    exp_t e; int lat; bit got;
    for (int i = 0; i < 8; i++) begin
      issue(va[i], vb[i], vs[i], vm[i], vc[i], ve[i]);
      wait_done(lat, got);
      e = sb.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL directed_%0d_timeout no done within 20 cycles required done", i);
      end else if ({y, cout_re, zero, ovf} !== e || lat != NSL) begin
        errors++;
        $display("FAIL directed_%0d got %h lat=%0d required %h lat=%0d",
                 i, {y, cout_re, zero, ovf}, lat, e, NSL);
      end
      cyc();
    end
  endtask

  task automatic test_ignored_start();
    exp_t e; int lat; bit got; int extra;
    issue(16'h1234, 16'h0FFF, 4'h9, 1'b0, 1'b1, exp_t'({16'h2233, 3'b100}));
    cyc(); cyc();
    a = 16'hFFFF; b = 16'hFFFF; s = 4'hc; m = 1'b1; cin_re = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(lat, got);
    e = sb.pop_front();
    checks++;
    if (!got || {y, cout_re, zero, ovf} !== e || lat != 1) begin
      errors++;
      $display("FAIL ignored_start got=%b %h lat=%0d required 1 %h lat=1",
               got, {y, cout_re, zero, ovf}, lat, e);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (done || busy) extra++; end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignored_no_second_op got %0d busy/done cycles required 0", extra);
    end
  endtask

  task automatic test_back_to_back(input int n, input bit rnd);
    logic [W-1:0] ra, rb; logic [3:0] rs; logic rm, rc;
    exp_t e; int lat; bit got;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        ra = W'($urandom); rb = W'($urandom); rs = 4'($urandom); rm = 1'($urandom); rc = 1'($urandom);
        if (i % 7 == 3) begin ra = 16'h7FFF; rb = 16'h0001; rs = 4'h9; rm = 1'b0; end
      end else begin
        ra = 16'h1000 * W'(i + 1); rb = 16'h0111; rs = 4'h9; rm = 1'b0; rc = 1'b1;
      end
      issue(ra, rb, rs, rm, rc, model(ra, rb, rs, rm, rc));
      wait_done(lat, got);
      e = sb.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL b2b_%0d_timeout no done within 20 cycles required done", i);
      end else if ({y, cout_re, zero, ovf} !== e || lat != NSL) begin
        errors++;
        $display("FAIL b2b_%0d a=%h b=%h s=%h m=%b cr=%b got %h lat=%0d required %h lat=%0d",
                 i, ra, rb, rs, rm, rc, {y, cout_re, zero, ovf}, lat, e, NSL);
      end
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat; bit got; int extra;
    issue(16'h1234, 16'h1111, 4'h9, 1'b0, 1'b0, exp_t'({16'h2346, 3'b100}));
    void'(sb.pop_back());
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if ({busy, done, y, cout_re, zero, ovf} !== {1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b y=%h cout_re=%b zero=%b ovf=%b required 0 0 0000 1 0 0",
               busy, done, y, cout_re, zero, ovf);
    end
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (done || busy) extra++; end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d busy/done cycles required 0", extra);
    end
    issue(16'h8000, 16'h8000, 4'h9, 1'b0, 1'b1, exp_t'({16'h0000, 3'b011}));
    wait_done(lat, got);
    e = sb.pop_front();
    checks++;
    if (!got || {y, cout_re, zero, ovf} !== e || lat != NSL) begin
      errors++;
      $display("FAIL reset_mid_fresh got=%b %h lat=%0d required 1 %h lat=%0d",
               got, {y, cout_re, zero, ovf}, lat, e, NSL);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_ignored_start();
    test_back_to_back(3, 1'b0);
    test_reset_mid();
    test_back_to_back(40, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
